// File: rtl/bus_pkg.sv
// bus_pkg: shared types for the I/D bus arbiter.
//   bus_state_e - arbiter FSM states (IDLE/ISSUE/WAIT)
//   bus_src_e   - which requester owns the in-flight access
//   mem_cmd_t   - one captured memory command (addr, wdata, mask, we)
package bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } bus_state_e;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } bus_src_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] mask;
        logic              we;
    } mem_cmd_t;

endpackage

// File: rtl/bus_arb_prio.sv
// bus_arb_prio: requester priority select with starvation guard.
//   clk_i, reset_i - clock, synchronous active-high reset
//   iReq, dReq     - instruction / data requests
//   idle           - arbiter can accept a request this cycle
//   iWin, dWin     - combinational winner (at most one high, only when idle)
// Data wins by default; once the instruction side has lost STARVE_MAX
// arbitrations in a row while requesting, it wins the next one.
module bus_arb_prio #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic iReq,
    input  logic dReq,
    input  logic idle,
    output logic iWin,
    output logic dWin
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0] starve_cnt;

    always_comb begin
        iWin = idle && iReq && (!dReq || (starve_cnt == STARVE_LIM));
        dWin = idle && dReq && !iWin;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_cnt <= '0;
        end else if (!iReq || iWin) begin
            starve_cnt <= '0;
        end else if (dWin && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one fixed-latency single-ported memory between the
// instruction-fetch read port and the data read/write port.
//   clk_i, reset_i             - clock, synchronous active-high reset
//   iReq_i/iAddr_i/iGnt_o      - instruction request, address, accept pulse
//   iRData_o/iValid_o          - instruction read data and its valid pulse
//   dReq_i/dWe_i/dAddr_i/
//   dWData_i/dWMask_i/dGnt_o   - data request, payload, accept pulse
//   dRData_o/dValid_o          - data read data and its valid pulse (reads)
//   memAddr_o/memWData_o/
//   memWMask_o/memRd_o/memWe_o - registered memory command
//   memRData_i                 - memory read data, LATENCY cycles after memRd_o
//   busy_o                     - arbiter not in IDLE
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              iReq_i,
    input  logic [ADDR_W-1:0] iAddr_i,
    output logic              iGnt_o,
    output logic [DATA_W-1:0] iRData_o,
    output logic              iValid_o,
    input  logic              dReq_i,
    input  logic              dWe_i,
    input  logic [ADDR_W-1:0] dAddr_i,
    input  logic [DATA_W-1:0] dWData_i,
    input  logic [MASK_W-1:0] dWMask_i,
    output logic              dGnt_o,
    output logic [DATA_W-1:0] dRData_o,
    output logic              dValid_o,
    output logic [ADDR_W-1:0] memAddr_o,
    output logic [DATA_W-1:0] memWData_o,
    output logic [MASK_W-1:0] memWMask_o,
    output logic              memRd_o,
    output logic              memWe_o,
    input  logic [DATA_W-1:0] memRData_i,
    output logic              busy_o
);

    localparam int unsigned CW = $clog2(LATENCY + 1);

    bus_state_e        state_q, state_d;
    mem_cmd_t          cmd_q, cmd_win;
    bus_src_e          src_q;
    logic [CW-1:0]     lat_cnt_q;
    logic              mem_rd_q, mem_we_q;
    logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
    logic              i_valid_q, d_valid_q;
    logic              idle, i_win, d_win;

    // Gating with reset keeps a request from being "accepted" in a cycle
    // whose state update is discarded.
    assign idle = (state_q == IDLE) && !reset_i;

    bus_arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .iReq   (iReq_i),
        .dReq   (dReq_i),
        .idle   (idle),
        .iWin   (i_win),
        .dWin   (d_win)
    );

    always_comb begin
        cmd_win = '0;
        if (d_win) begin
            cmd_win.addr  = dAddr_i;
            cmd_win.wdata = dWData_i;
            cmd_win.mask  = dWMask_i;
            cmd_win.we    = dWe_i;
        end else begin
            cmd_win.addr  = iAddr_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_win || d_win) state_d = ISSUE;
            ISSUE:   state_d = cmd_q.we ? IDLE : WAIT;
            WAIT:    if (lat_cnt_q == CW'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            src_q     <= SRC_I;
            lat_cnt_q <= '0;
            mem_rd_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_rd_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Strobes are loaded on the grant edge so they are
                    // visible exactly during the ISSUE cycle.
                    if (i_win || d_win) begin
                        cmd_q    <= cmd_win;
                        src_q    <= d_win ? SRC_D : SRC_I;
                        mem_rd_q <= !cmd_win.we;
                        mem_we_q <= cmd_win.we;
                    end
                end
                ISSUE: begin
                    if (!cmd_q.we) lat_cnt_q <= CW'(LATENCY);
                end
                WAIT: begin
                    if (lat_cnt_q == CW'(1)) begin
                        if (src_q == SRC_D) begin
                            d_rdata_q <= memRData_i;
                            d_valid_q <= 1'b1;
                        end else begin
                            i_rdata_q <= memRData_i;
                            i_valid_q <= 1'b1;
                        end
                    end else begin
                        lat_cnt_q <= lat_cnt_q - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign iGnt_o     = i_win;
    assign dGnt_o     = d_win;
    assign iRData_o   = i_rdata_q;
    assign iValid_o   = i_valid_q;
    assign dRData_o   = d_rdata_q;
    assign dValid_o   = d_valid_q;
    assign memAddr_o  = cmd_q.addr;
    assign memWData_o = cmd_q.wdata;
    assign memWMask_o = cmd_q.mask;
    assign memRd_o    = mem_rd_q;
    assign memWe_o    = mem_we_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: two arbiters (LATENCY=1/STARVE_MAX=4 and
// LATENCY=3/STARVE_MAX=2) each with its own memory responder. A
// transaction-level model (occupancy windows, pending read data, loss
// count) is checked every cycle, plus directed literal expectations.
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]       i_req = '0, i_gnt, i_valid;
    logic [1:0]       d_req = '0, d_we = '0, d_gnt, d_valid;
    logic [1:0]       mem_rd, mem_we, busy;
    logic [1:0][31:0] i_addr = '0, i_rdata, d_addr = '0, d_wdata = '0, d_rdata;
    logic [1:0][31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [1:0][3:0]  d_wmask = '0, mem_wmask;

    bus_arbiter #(.LATENCY(1), .STARVE_MAX(4)) u_dut0 (
        .clk_i(clk), .reset_i(rst),
        .iReq_i(i_req[0]), .iAddr_i(i_addr[0]), .iGnt_o(i_gnt[0]),
        .iRData_o(i_rdata[0]), .iValid_o(i_valid[0]),
        .dReq_i(d_req[0]), .dWe_i(d_we[0]), .dAddr_i(d_addr[0]),
        .dWData_i(d_wdata[0]), .dWMask_i(d_wmask[0]), .dGnt_o(d_gnt[0]),
        .dRData_o(d_rdata[0]), .dValid_o(d_valid[0]),
        .memAddr_o(mem_addr[0]), .memWData_o(mem_wdata[0]), .memWMask_o(mem_wmask[0]),
        .memRd_o(mem_rd[0]), .memWe_o(mem_we[0]), .memRData_i(mem_rdata[0]),
        .busy_o(busy[0])
    );

    bus_arbiter #(.LATENCY(3), .STARVE_MAX(2)) u_dut1 (
        .clk_i(clk), .reset_i(rst),
        .iReq_i(i_req[1]), .iAddr_i(i_addr[1]), .iGnt_o(i_gnt[1]),
        .iRData_o(i_rdata[1]), .iValid_o(i_valid[1]),
        .dReq_i(d_req[1]), .dWe_i(d_we[1]), .dAddr_i(d_addr[1]),
        .dWData_i(d_wdata[1]), .dWMask_i(d_wmask[1]), .dGnt_o(d_gnt[1]),
        .dRData_o(d_rdata[1]), .dValid_o(d_valid[1]),
        .memAddr_o(mem_addr[1]), .memWData_o(mem_wdata[1]), .memWMask_o(mem_wmask[1]),
        .memRd_o(mem_rd[1]), .memWe_o(mem_we[1]), .memRData_i(mem_rdata[1]),
        .busy_o(busy[1])
    );

    int lat  [2] = '{1, 3};
    int smax [2] = '{4, 2};

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int n, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %h, expected %h (t=%0t)", name, n, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name, input int n);
        n_vec++;
        n_err++;
        $display("FAIL %s dut%0d: timed out (t=%0t)", name, n, $time);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // Memory contents: env_ram is written by the DUT's strobes, mram by the model.
    logic [31:0] env_ram [2][256];
    logic [31:0] mram    [2][256];
    int          due     [2] = '{-1, -1};
    logic [7:0]  raddr   [2];

    // Transaction model state.
    int          free_at  [2] = '{0, 0};
    int          issue_at [2] = '{-1, -1};
    int          valid_at [2] = '{-1, -1};
    bit          issue_we [2];
    logic [31:0] issue_addr [2], issue_wdata [2];
    logic [3:0]  issue_mask [2];
    bit          vsrc_d [2];
    logic [31:0] pend [2];
    logic [31:0] exp_ir [2] = '{32'h0, 32'h0};
    logic [31:0] exp_dr [2] = '{32'h0, 32'h0};
    int          losses [2] = '{0, 0};
    bit          armed = 1'b0;

    always @(negedge clk) begin
        for (int n = 0; n < 2; n++) begin
            bit idle, iw, dw, strobe;
            // memory responder
            mem_rdata[n] = (cyc == due[n]) ? env_ram[n][raddr[n]] : (32'hBAD0_0000 ^ 32'(cyc));
            if (mem_we[n] === 1'b1)
                env_ram[n][mem_addr[n][9:2]] = merge(env_ram[n][mem_addr[n][9:2]],
                                                     mem_wdata[n], mem_wmask[n]);
            if (mem_rd[n] === 1'b1) begin
                due[n]   = cyc + lat[n];
                raddr[n] = mem_addr[n][9:2];
            end

            idle = (cyc >= free_at[n]) && !rst;
            iw   = idle && i_req[n] && (!d_req[n] || losses[n] == smax[n]);
            dw   = idle && d_req[n] && !iw;
            if (cyc == valid_at[n]) begin
                if (vsrc_d[n]) exp_dr[n] = pend[n];
                else           exp_ir[n] = pend[n];
            end
            strobe = (cyc == issue_at[n]);

            if (armed) begin
                check("i_gnt",   n, i_gnt[n],   iw);
                check("d_gnt",   n, d_gnt[n],   dw);
                check("busy",    n, busy[n],    cyc < free_at[n]);
                check("mem_rd",  n, mem_rd[n],  strobe && !issue_we[n]);
                check("mem_we",  n, mem_we[n],  strobe && issue_we[n]);
                check("i_valid", n, i_valid[n], cyc == valid_at[n] && !vsrc_d[n]);
                check("d_valid", n, d_valid[n], cyc == valid_at[n] && vsrc_d[n]);
                check("i_rdata", n, i_rdata[n], exp_ir[n]);
                check("d_rdata", n, d_rdata[n], exp_dr[n]);
                if (strobe) check("mem_addr", n, mem_addr[n], issue_addr[n]);
                if (strobe && issue_we[n]) begin
                    check("mem_wdata", n, mem_wdata[n], issue_wdata[n]);
                    check("mem_wmask", n, mem_wmask[n], issue_mask[n]);
                end
            end

            if (strobe && issue_we[n])
                mram[n][issue_addr[n][9:2]] = merge(mram[n][issue_addr[n][9:2]],
                                                    issue_wdata[n], issue_mask[n]);

            if (rst) begin
                free_at[n] = 0; issue_at[n] = -1; valid_at[n] = -1;
                exp_ir[n] = '0; exp_dr[n] = '0; losses[n] = 0;
            end else begin
                if (!i_req[n] || iw)                 losses[n] = 0;
                else if (dw && losses[n] < smax[n])  losses[n]++;
                if (iw || dw) begin
                    issue_at[n]    = cyc + 1;
                    issue_we[n]    = dw && d_we[n];
                    issue_addr[n]  = dw ? d_addr[n] : i_addr[n];
                    issue_wdata[n] = d_wdata[n];
                    issue_mask[n]  = d_wmask[n];
                    vsrc_d[n]      = dw;
                    if (issue_we[n]) begin
                        free_at[n]  = cyc + 2;
                        valid_at[n] = -1;
                    end else begin
                        free_at[n]  = cyc + 2 + lat[n];
                        valid_at[n] = cyc + 2 + lat[n];
                        pend[n]     = mram[n][issue_addr[n][9:2]];
                    end
                end
            end
        end
        if (rst) armed = 1'b1;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic d_access(input int n, input bit we, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] m, output int gcyc);
        bit got = 0;
        gcyc = -1;
        d_req[n] = 1'b1; d_we[n] = we; d_addr[n] = a; d_wdata[n] = wd; d_wmask[n] = m;
        for (int k = 0; k < 40 && !got; k++) begin
            #1;
            if (d_gnt[n]) begin got = 1; gcyc = cyc; end
            next_cycle();
        end
        d_req[n] = 1'b0;
        if (!got) timeout("d_access_gnt", n);
    endtask

    task automatic wait_idle(input int n);
        for (int k = 0; k < 40; k++) begin
            if (busy[n] === 1'b0) return;
            next_cycle();
        end
        timeout("wait_idle", n);
    endtask

    task automatic wait_dvalid(input int n, input logic [31:0] exp, input string name);
        for (int k = 0; k < 40; k++) begin
            if (d_valid[n] === 1'b1) begin
                check(name, n, d_rdata[n], exp);
                return;
            end
            next_cycle();
        end
        timeout(name, n);
    endtask

    task automatic chk_all_zero(input int n);
        check("rst_i_gnt",   n, i_gnt[n], 0);     check("rst_d_gnt",   n, d_gnt[n], 0);
        check("rst_i_valid", n, i_valid[n], 0);   check("rst_d_valid", n, d_valid[n], 0);
        check("rst_mem_rd",  n, mem_rd[n], 0);    check("rst_mem_we",  n, mem_we[n], 0);
        check("rst_busy",    n, busy[n], 0);      check("rst_mem_addr", n, mem_addr[n], 0);
        check("rst_mem_wdata", n, mem_wdata[n], 0);
        check("rst_mem_wmask", n, mem_wmask[n], 0);
        check("rst_i_rdata", n, i_rdata[n], 0);   check("rst_d_rdata", n, d_rdata[n], 0);
    endtask

    initial begin
        int g, gi;
        logic [31:0] seq [2];
        int          ng  [2];
        bit          got;

        for (int n = 0; n < 2; n++)
            for (int i = 0; i < 256; i++) begin
                env_ram[n][i] = (32'(i) * 32'h0101_0101) ^ 32'hC0DE_0000;
                mram[n][i]    = env_ram[n][i];
            end
        env_ram[0][8'h40] = 32'hDEAD_BEEF;
        mram[0][8'h40]    = 32'hDEAD_BEEF;

        rst = 1'b1;
        repeat (2) next_cycle();
        rst = 1'b0;
        #1;
        chk_all_zero(0);
        chk_all_zero(1);

        // single instruction read, LATENCY=1
        next_cycle();
        i_req[0] = 1'b1; i_addr[0] = 32'h100;
        #1 check("sr_gnt_c0", 0, i_gnt[0], 1);
        next_cycle();
        i_req[0] = 1'b0; i_addr[0] = '0;
        #1 check("sr_rd_c1", 0, mem_rd[0], 1);
        check("sr_addr_c1", 0, mem_addr[0], 32'h100);
        next_cycle();
        #1 check("sr_valid_c2", 0, i_valid[0], 0);
        next_cycle();
        #1 check("sr_valid_c3", 0, i_valid[0], 1);
        check("sr_rdata_c3", 0, i_rdata[0], 32'hDEAD_BEEF);

        // single write
        next_cycle();
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h200;
        d_wdata[0] = 32'h1234_5678; d_wmask[0] = 4'hF;
        #1 check("sw_gnt_c0", 0, d_gnt[0], 1);
        check("sw_we_c0", 0, mem_we[0], 0);
        next_cycle();
        d_req[0] = 1'b0;
        #1 check("sw_we_c1", 0, mem_we[0], 1);
        check("sw_wdata_c1", 0, mem_wdata[0], 32'h1234_5678);
        next_cycle();
        #1 check("sw_we_c2", 0, mem_we[0], 0);
        check("sw_busy_c2", 0, busy[0], 0);

        // partial write then read back
        d_access(0, 1'b1, 32'h200, 32'hAAAA_BBBB, 4'h3, g);
        wait_idle(0);
        d_access(0, 1'b0, 32'h200, 32'h0, 4'h0, g);
        wait_dvalid(0, 32'h1234_BBBB, "mask_readback");
        next_cycle();

        // starvation: both sides held continuously on both DUTs
        for (int n = 0; n < 2; n++) begin
            i_req[n] = 1'b1; i_addr[n] = 32'h100;
            d_req[n] = 1'b1; d_we[n] = 1'b1; d_addr[n] = 32'h380;
            d_wdata[n] = 32'h0F0F_0F0F; d_wmask[n] = 4'hF;
            seq[n] = '0; ng[n] = 0;
        end
        for (int k = 0; k < 80 && (ng[0] < 10 || ng[1] < 6); k++) begin
            #1;
            for (int n = 0; n < 2; n++)
                if ((i_gnt[n] || d_gnt[n]) && ng[n] < (n == 0 ? 10 : 6)) begin
                    seq[n] = (seq[n] << 1) | 32'(i_gnt[n]);
                    ng[n]++;
                end
            next_cycle();
        end
        i_req = '0; d_req = '0;
        check("starve_seq", 0, seq[0], 32'b00_0010_0001);
        check("starve_seq", 1, seq[1], 32'b00_1001);
        check("starve_cnt", 0, ng[0], 10);
        check("starve_cnt", 1, ng[1], 6);
        wait_idle(0);
        wait_idle(1);
        next_cycle();

        // held instruction request during a data read's WAIT, LATENCY=3
        d_access(1, 1'b0, 32'h040, 32'h0, 4'h0, g);
        next_cycle();
        i_req[1] = 1'b1; i_addr[1] = 32'h0C0;
        got = 0; gi = -1;
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (i_gnt[1]) begin
                got = 1; gi = cyc;
                check("held_dvalid_at_gnt", 1, d_valid[1], 1);
                check("held_drdata", 1, d_rdata[1], 32'hD0CE_1010);
                check("held_busy_at_gnt", 1, busy[1], 0);
            end
            next_cycle();
        end
        i_req[1] = 1'b0;
        if (!got) timeout("held_gnt", 1);
        else check("held_gnt_delay", 1, 32'(gi - g), 5);
        wait_idle(1);
        next_cycle();

        // reset in WAIT, LATENCY=3
        d_access(1, 1'b0, 32'h044, 32'h0, 4'h0, g);
        next_cycle();
        next_cycle();
        rst = 1'b1;
        #1 check("rm_busy_in_wait", 1, busy[1], 1);
        next_cycle();
        rst = 1'b0;
        #1 chk_all_zero(1);
        chk_all_zero(0);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            #1 check("rm_no_dvalid", 1, d_valid[1], 0);
        end

        // zero-mask write, then read back unchanged contents
        next_cycle();
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h300;
        d_wdata[0] = 32'h55AA_55AA; d_wmask[0] = 4'h0;
        #1 check("zm_gnt", 0, d_gnt[0], 1);
        next_cycle();
        d_req[0] = 1'b0;
        #1 check("zm_we", 0, mem_we[0], 1);
        check("zm_mask", 0, mem_wmask[0], 0);
        check("zm_busy_c1", 0, busy[0], 1);
        next_cycle();
        #1 check("zm_busy_c2", 0, busy[0], 0);
        d_access(0, 1'b0, 32'h300, 32'h0, 4'h0, g);
        wait_dvalid(0, 32'h001E_C0C0, "zm_readback");

        repeat (4) next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
